dff_bank_arbiter: RTL
=====================

# dff_bank_arbiter

- Shares a bank of DEPTH enable-gated DFF registers (WIDTH bits each) between four write requesters.
- Arbitration is round-robin with a REQ/GNT handshake. Exactly one register is written per granted cycle.
- A sequenced sweep clears the whole bank one register per cycle.
- Sits between the requesting datapath blocks and the per-register DFF ENABLE/D_IN controls. It owns the bank and provides one combinational read port.

## Interface
- WIDTH, 8, data bits per register
- DEPTH, 4, number of registers; power of two, ≥2; AW = log2(DEPTH)
- CLOCK  in  1  system clock; all state updates on rising edge
- CLEAR  in  1  reset, asynchronous, active-low
- REQ  in  4  write request per port i, level, held until granted
- WR_ADDR  in  4*AW  port i address at [i*AW +: AW]
- WR_DATA  in  4*WIDTH  port i data at [i*WIDTH +: WIDTH]
- SWEEP  in  1  single-cycle request to clear the entire bank
- RD_ADDR  in  AW  read address
- RD_DATA  out  WIDTH  bank[RD_ADDR], combinational from register outputs
- GNT  out  4  registered one-hot grant pulse, at most one bit high
- BUSY  out  1  high while a sweep is in progress

## Operation
**FSM states**
- IDLE: arbitrates write requests.
- SWEEP: clears the bank.

**Internal state**
- PRIO, 2-bit round-robin pointer; reset value 0.
- SCNT, AW-bit sweep counter; reset value 0.

**Eligibility and arbitration (IDLE)**
- Port i is eligible if REQ[i]=1 and GNT[i]=0 in the current cycle. A just-granted port is masked for one cycle.
- The winner g is the first eligible port scanning PRIO, PRIO+1, … mod 4.

**On the edge, with winner g (IDLE)**
- bank[WR_ADDR[g]] <= WR_DATA[g].
- GNT <= one-hot(g).
- PRIO <= g+1 mod 4.

**On the edge, no eligible port (IDLE)**
- GNT <= 0; PRIO unchanged.

**SWEEP handling**
- IDLE with SWEEP=1: go to SWEEP, SCNT <= 0, GNT <= 0, no write. SWEEP takes priority over simultaneous REQs.
- In SWEEP, each edge: bank[SCNT] <= 0, SCNT <= SCNT+1.
- When SCNT = DEPTH-1, that edge clears the last register and returns to IDLE.
- In SWEEP: GNT held 0, PRIO frozen, REQs stall.
- SWEEP asserted while in SWEEP is ignored; the sweep is not restarted or extended.
- BUSY = (state == SWEEP); decoded from registered state.

**Requester rule**
- Keep REQ, WR_ADDR and WR_DATA stable until the cycle where GNT[i]=1.
- Deasserting REQ in that cycle ends the transaction.
- REQ still high in that cycle is a new transaction, arbitrated from the next cycle.

**Read and collision rules**
- Read-during-write: RD_DATA shows the pre-edge value and updates after the edge.
- Two ports targeting the same address: the value of the later grant persists.

## Timing
- Reset (CLEAR=0) acts immediately, without a clock edge:
  - bank all 0, GNT=0, BUSY=0, PRIO=0, SCNT=0, state IDLE.
  - RD_DATA therefore reads 0 at every address.
- Reset mid-sweep aborts the sweep; after release the FSM is in IDLE.
- Deassertion of CLEAR is synchronous to CLOCK; the first arbitration occurs at the first rising edge after release.
- Write latency: REQ sampled at edge k → register written at edge k, GNT high in the cycle k→k+1, RD_DATA new from edge k.
- Single continuous requester: granted every second cycle (mask rule). Two or more requesters: one grant per cycle, rotating.
- Sweep: SWEEP sampled at edge k → BUSY high from k; registers 0..DEPTH-1 cleared at edges k+1..k+DEPTH.
  - BUSY low after edge k+DEPTH.
  - The earliest grant is at edge k+DEPTH+1.
- PRIO wraps 3→0; SCNT wraps DEPTH-1→0 on sweep exit.

## Test plan
- Reset: CLEAR pulsed low mid-cycle after writes → GNT=0, BUSY=0 and RD_DATA=0 at all 4 addresses, without a clock edge.
- Single port: REQ=0001, WR_ADDR0=2, WR_DATA0=8'hA5, REQ held → GNT pattern 0001,0000,0001,…; RD_ADDR=2 reads 8'hA5 from the first edge.
- Round-robin: REQ=1111 held with ADDR i=i and DATA 8'h11/22/33/44 → GNT 0001,0010,0100,1000,0001; addresses 0..3 read 11,22,33,44.
- Collision and pointer: PRIO=0; ports 1 and 3 both request, both at address 1 with data 8'h5A / 8'hC3 → port 1 is granted first, then port 3; address 1 reads 8'hC3.
- Sweep with contention: bank preloaded nonzero, SWEEP and REQ=0010 in the same cycle → BUSY high 4 cycles and GNT=0 throughout; all registers 0; GNT=0010 in the cycle after BUSY falls.
- Reset mid-sweep: CLEAR low when SCNT=2 → BUSY=0 immediately; after release REQ=0100 is granted at the first edge.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin four-port write arbiter owning a DFF register bank
// Includes a sequenced clear sweep and one combinational read port.
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               CLOCK,
  input  logic               CLEAR,
  input  logic [3:0]         REQ,
  input  logic [4*AW-1:0]    WR_ADDR,
  input  logic [4*WIDTH-1:0] WR_DATA,
  input  logic               SWEEP,
  input  logic [AW-1:0]      RD_ADDR,
  output logic [WIDTH-1:0]   RD_DATA,
  output logic [3:0]         GNT,
  output logic               BUSY
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         prio_q, prio_d;
  logic [AW-1:0]      scnt_q, scnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   bank_q [DEPTH];
  logic [WIDTH-1:0]   bank_d [DEPTH];

  logic [AW-1:0]      addr_a [4];
  logic [WIDTH-1:0]   data_a [4];
  logic [3:0]         elig;
  logic               found;
  logic [1:0]         win;
  logic [1:0]         idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = WR_ADDR[i*AW +: AW];
      data_a[i] = WR_DATA[i*WIDTH +: WIDTH];
    end
  end

  // A port granted last cycle is masked so its follow-on request waits one cycle.
  assign elig = REQ & ~gnt_q;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = prio_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    scnt_d  = scnt_q;
    gnt_d   = 4'b0000;
    bank_d  = bank_q;
    case (state_q)
      S_IDLE: begin
        if (SWEEP) begin
          state_d = S_SWEEP;
          scnt_d  = '0;
        end else if (found) begin
          bank_d[addr_a[win]] = data_a[win];
          gnt_d[win]          = 1'b1;
          prio_d              = win + 2'd1;
        end
      end
      S_SWEEP: begin
        bank_d[scnt_q] = '0;
        scnt_d         = scnt_q + 1'b1;
        if (scnt_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_q <= S_IDLE;
      prio_q  <= 2'd0;
      scnt_q  <= '0;
      gnt_q   <= 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      scnt_q  <= scnt_d;
      gnt_q   <= gnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign RD_DATA = bank_q[RD_ADDR];
  assign GNT     = gnt_q;
  assign BUSY    = (state_q == S_SWEEP);

endmodule
